stream_mux_n: RTL and testbench
===============================

// Module: stream_mux_n
// PURPOSE
//   Parametrised N-input stream multiplexer with a registered output and
//   valid/ready handshake on every channel. Successor of the plain
//   combinational 4:1 select mux used in datapath operand/writeback paths.
//   Used where the selected source is a producer that can stall, e.g.
//   writeback arbitration or fetch/LSU bus sharing. Adds a 1-cycle
//   registered output and correct backpressure per channel.
// PARAMETERS
//   WIDTH      32   data bits per channel
//   INPUTS     4    number of input channels, 2..16
//   SEL_WIDTH  localparam = $clog2(INPUTS), width of select/channel tag
// PORTS
//   i_Clock    in   1                 single clock, rising edge
//   i_Reset    in   1                 synchronous, active-high
//   i_Select   in   SEL_WIDTH         channel to accept from this cycle
//   i_Input    in   INPUTS*WIDTH      channel k data at [k*WIDTH +: WIDTH]
//   i_Valid    in   INPUTS            per-channel valid
//   o_Ready    out  INPUTS            per-channel ready (one-hot or zero)
//   o_Output   out  WIDTH             registered data
//   o_Channel  out  SEL_WIDTH         index of channel that produced o_Output
//   o_Valid    out  1                 o_Output/o_Channel valid
//   i_Ready    in   1                 downstream accepts when o_Valid & i_Ready
// BEHAVIOUR
//   - Reset (sync, high): o_Valid=0, o_Output=0, o_Channel=0, internal
//     skid state cleared; o_Ready=0 on every channel while i_Reset=1.
//   - Transfer in: channel s=i_Select fires when i_Valid[s] & o_Ready[s].
//     o_Ready[k]=0 for every k!=s. Select >= INPUTS: all o_Ready=0, no fire.
//   - Transfer out: o_Valid & i_Ready. o_Output/o_Channel stable while
//     o_Valid=1 and i_Ready=0 (AXI-stream rules; o_Valid never drops
//     without a transfer).
//   - Latency: 1 cycle input fire -> o_Valid. Throughput 1 word/cycle.
//   - i_Select may change any cycle; it only matters in the cycle it is
//     sampled with a fire. Data captured is i_Input[s] of the fire cycle.
//   - States (base build): EMPTY (o_Valid=0), HOLD (o_Valid=1).
//     EMPTY -fire-> HOLD. HOLD -out&!fire-> EMPTY. HOLD -out&fire-> HOLD
//     (new word). HOLD -!out-> HOLD. o_Ready[s] = !o_Valid | i_Ready.
//   - Reset mid-operation: held word discarded, no output transfer.
// CONFIGURATION
//   STREAM_MUX_SKID_EN defined: o_Ready is a register output (no
//     combinational path i_Ready -> o_Ready). 2-entry skid: states EMPTY,
//     HOLD, FULL. o_Ready[s] = (state!=FULL) registered. HOLD -fire&!out->
//     FULL (word parked in skid reg). FULL -out-> HOLD (skid moves to
//     output). FULL never fires. Latency still 1 cycle, throughput 1/cycle.
//   Not defined: base build above; o_Ready combinational from i_Ready.
// STRUCTURE
//   Package stream_mux_pkg: state enum (ST_EMPTY, ST_HOLD, ST_FULL),
//   MAX_INPUTS=16 constant, function to slice channel k from i_Input.
//   Sub-module stream_skid_buffer (WIDTH+SEL_WIDTH wide) instantiated
//   only under STREAM_MUX_SKID_EN; selection logic stays in this module.
// TESTING (run both with and without STREAM_MUX_SKID_EN)
//   - Reset: i_Reset=1 2 cycles with i_Valid=4'hF -> o_Valid=0,
//     o_Output=0, o_Ready=4'h0; first cycle after release o_Ready[sel]=1.
//   - Streaming: sel=2, i_Input[2]=0xA5A5_0001.., i_Valid[2]=1, i_Ready=1
//     10 cycles -> 10 words out in order, o_Channel=2, 1-cycle latency.
//   - Backpressure: i_Ready=0 for 3 cycles with o_Valid=1 -> o_Output
//     stable, base: o_Ready[2]=0; skid: one extra word accepted then
//     o_Ready=0; no loss/duplication after i_Ready=1.
//   - Select hop: sel 0,1,3,0 on consecutive cycles all valid, data
//     0x10,0x11,0x13,0x20 -> outputs same order, o_Channel 0,1,3,0.
//   - Out-of-range: INPUTS=3, sel=3, i_Valid=3'b111 -> o_Ready=0, no fire.
//   - Reset mid-stream: assert i_Reset while HOLD/FULL -> next cycle
//     o_Valid=0, held words never appear on o_Output.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared state encoding, limits and channel slicing for stream_mux_n.
package stream_mux_pkg;
    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_FULL} state_t;
    localparam int MAX_INPUTS = 16;
    localparam int MAX_WIDTH = 64;
    localparam int BUS_BITS = MAX_INPUTS * MAX_WIDTH;
    function automatic logic [MAX_WIDTH-1:0] chan_slice(input logic [BUS_BITS-1:0] bus, input int width, input int k);
        logic [BUS_BITS-1:0] shifted;
        shifted = bus >> (k * width);
        return shifted[MAX_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer: 2-entry output register plus skid slot with a registered in_ready.
module stream_skid_buffer
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    state_t state, state_next;
    logic [WIDTH-1:0] skid_data;
    logic out_fire;
    assign out_valid = state != ST_EMPTY;
    assign out_fire = out_valid && out_ready;
    always_comb begin
        state_next = state;
        state_next = state == ST_EMPTY ? (in_valid ? ST_HOLD : ST_EMPTY)
                   : state == ST_HOLD  ? (out_fire ? (in_valid ? ST_HOLD : ST_EMPTY) : (in_valid ? ST_FULL : ST_HOLD))
                   : (out_fire ? ST_HOLD : ST_FULL);
    end
    // in_valid is already qualified by in_ready, so FULL never sees it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            state    <= state_next;
            in_ready <= state_next != ST_FULL;
            if (in_valid && (state == ST_EMPTY || out_fire))
                out_data <= in_data;
            else if (state == ST_FULL && out_fire)
                out_data <= skid_data;
            if (in_valid && state == ST_HOLD && !out_fire)
                skid_data <= in_data;
        end
    end
endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-input valid/ready stream mux with a registered output stage.
// Define STREAM_MUX_SKID_EN to register o_Ready through a 2-entry skid buffer.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int INPUTS = 4,
    localparam int SEL_WIDTH = $clog2(INPUTS)
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic [SEL_WIDTH-1:0]    i_Select,
    input  logic [INPUTS*WIDTH-1:0] i_Input,
    input  logic [INPUTS-1:0]       i_Valid,
    output logic [INPUTS-1:0]       o_Ready,
    output logic [WIDTH-1:0]        o_Output,
    output logic [SEL_WIDTH-1:0]    o_Channel,
    output logic                    o_Valid,
    input  logic                    i_Ready
);
    localparam int SEL_SPAN = 1 << SEL_WIDTH;
    logic [SEL_SPAN-1:0] valid_ext;
    logic [BUS_BITS-1:0] bus_ext;
    logic [WIDTH-1:0] sel_data;
    logic sel_ok, can_accept, fire;
    always_comb begin
        valid_ext = SEL_SPAN'(i_Valid);
        bus_ext = BUS_BITS'(i_Input);
        sel_data = WIDTH'(chan_slice(bus_ext, WIDTH, int'(i_Select)));
        sel_ok = int'(i_Select) < INPUTS;
        fire = sel_ok && can_accept && valid_ext[i_Select];
        o_Ready = (sel_ok && can_accept) ? INPUTS'(1) << i_Select : '0;
    end
`ifdef STREAM_MUX_SKID_EN
    logic skid_ready;
    logic [WIDTH+SEL_WIDTH-1:0] out_word;
    assign can_accept = !i_Reset && skid_ready;
    assign {o_Channel, o_Output} = out_word;
    stream_skid_buffer #(.WIDTH(WIDTH + SEL_WIDTH)) u_skid (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .in_valid  (fire),
        .in_data   ({i_Select, sel_data}),
        .in_ready  (skid_ready),
        .out_valid (o_Valid),
        .out_ready (i_Ready),
        .out_data  (out_word)
    );
`else
    state_t state, state_next;
    assign can_accept = !i_Reset && (state == ST_EMPTY || i_Ready);
    assign o_Valid = state == ST_HOLD;
    always_comb begin
        state_next = state;
        if (fire)
            state_next = ST_HOLD;
        else if (i_Ready)
            state_next = ST_EMPTY;
    end
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= ST_EMPTY;
            o_Output  <= '0;
            o_Channel <= '0;
        end else begin
            state <= state_next;
            if (fire) begin
                o_Output  <= sel_data;
                o_Channel <= i_Select;
            end
        end
    end
`endif
endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: scoreboard bench for stream_mux_n, base or STREAM_MUX_SKID_EN build.
module tb_stream_mux_n;
`ifdef STREAM_MUX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    logic i_Clock = 1'b0;
    logic i_Reset;
    logic [1:0] i_Select;
    logic [127:0] i_Input;
    logic [3:0] i_Valid, o_Ready;
    logic [31:0] o_Output;
    logic [1:0] o_Channel;
    logic o_Valid, i_Ready;
    logic [1:0] sel3;
    logic [95:0] in3;
    logic [2:0] val3, rdy3;
    logic [31:0] out3;
    logic [1:0] ch3;
    logic ov3, ir3;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit lat_chk = 1'b0;
    logic [33:0] exp_q[$];
    int cyc_q[$];

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc <= cyc + 1;

    stream_mux_n #(.WIDTH(32), .INPUTS(4)) u_dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Select(i_Select), .i_Input(i_Input),
        .i_Valid(i_Valid), .o_Ready(o_Ready), .o_Output(o_Output), .o_Channel(o_Channel),
        .o_Valid(o_Valid), .i_Ready(i_Ready)
    );
    stream_mux_n #(.WIDTH(32), .INPUTS(3)) u_dut3 (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Select(sel3), .i_Input(in3),
        .i_Valid(val3), .o_Ready(rdy3), .o_Output(out3), .o_Channel(ch3),
        .o_Valid(ov3), .i_Ready(ir3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected word
    always @(negedge i_Clock) begin
        logic [33:0] e;
        int c;
        if (!i_Reset && o_Valid && i_Ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected no output", {o_Channel, o_Output});
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("sb_word", {o_Channel, o_Output}, e);
                if (lat_chk) check("sb_latency", cyc - c, 1);
            end
        end
    end

    task automatic send(input int sel, input logic [31:0] data, input logic [3:0] also, input bit push);
        int n = 0;
        i_Select = 2'(sel);
        i_Input[sel*32 +: 32] = data;
        i_Valid = also;
        i_Valid[sel] = 1'b1;
        @(negedge i_Clock);
        while (!o_Ready[sel] && n < 20) begin
            @(negedge i_Clock);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ch%0d ready=0 expected 1", sel);
        end else if (push) begin
            exp_q.push_back({2'(sel), data});
            cyc_q.push_back(cyc);
        end
        @(posedge i_Clock);
        #1;
        i_Valid = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge i_Clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end
        @(posedge i_Clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Reset = 1'b1;
        i_Select = 2'd2;
        i_Input = '0;
        i_Valid = 4'hF;
        i_Ready = 1'b1;
        sel3 = 2'd0;
        in3 = '0;
        val3 = '0;
        ir3 = 1'b1;
        repeat (2) @(posedge i_Clock);
        @(negedge i_Clock);
        check("rst_valid", o_Valid, 0);
        check("rst_output", o_Output, 0);
        check("rst_channel", o_Channel, 0);
        check("rst_ready", o_Ready, 4'h0);
        @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        i_Valid = '0;
        @(negedge i_Clock);
        check("post_rst_ready", o_Ready, 4'b0100);
        check("post_rst_valid", o_Valid, 0);
        @(posedge i_Clock);
        #1;
        // Streaming: ten back-to-back words on channel 2
        lat_chk = 1'b1;
        for (int k = 1; k <= 10; k++) send(2, 32'hA5A5_0000 + 32'(k), 4'h0, 1'b1);
        drain();
        lat_chk = 1'b0;
        // Backpressure: downstream stalls for three cycles
        i_Ready = 1'b0;
        send(2, 32'hB000_0000, 4'h0, 1'b1);
        i_Select = 2'd2;
        i_Input[64 +: 32] = 32'hB000_0001;
        i_Valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_Clock);
            check("bp_valid", o_Valid, 1);
            check("bp_output", o_Output, 32'hB000_0000);
            check("bp_channel", o_Channel, 2);
            check("bp_ready", o_Ready, (SKID && k == 0) ? 4'b0100 : 4'b0000);
            if (SKID && k == 0) begin
                exp_q.push_back({2'd2, 32'hB000_0001});
                cyc_q.push_back(cyc);
            end
            @(posedge i_Clock);
            #1;
            if (SKID) i_Valid = '0;
        end
        i_Ready = 1'b1;
        if (!SKID) send(2, 32'hB000_0001, 4'h0, 1'b1);
        drain();
        // Select hop with every channel valid
        i_Input = {32'h0000_0E03, 32'h0000_0E02, 32'h0000_0E01, 32'h0000_0E00};
        lat_chk = 1'b1;
        send(0, 32'h10, 4'hF, 1'b1);
        send(1, 32'h11, 4'hF, 1'b1);
        send(3, 32'h13, 4'hF, 1'b1);
        send(0, 32'h20, 4'hF, 1'b1);
        drain();
        lat_chk = 1'b0;
        // Out-of-range select on a 3-input instance
        sel3 = 2'd3;
        val3 = 3'b111;
        in3 = {32'h32, 32'h31, 32'h30};
        for (int k = 0; k < 3; k++) begin
            @(negedge i_Clock);
            check("oor_ready", rdy3, 3'b000);
            check("oor_valid", ov3, 0);
            @(posedge i_Clock);
            #1;
        end
        sel3 = 2'd1;
        @(negedge i_Clock);
        check("dut3_ready", rdy3, 3'b010);
        @(posedge i_Clock);
        #1;
        val3 = '0;
        @(negedge i_Clock);
        check("dut3_valid", ov3, 1);
        check("dut3_output", out3, 32'h31);
        check("dut3_channel", ch3, 1);
        @(posedge i_Clock);
        #1;
        // Reset while words are held: they must never appear
        i_Ready = 1'b0;
        send(2, 32'hC000_0000, 4'h0, 1'b0);
        i_Select = 2'd2;
        i_Input[64 +: 32] = 32'hC000_0001;
        i_Valid = 4'b0100;
        @(negedge i_Clock);
        check("mid_ready", o_Ready, SKID ? 4'b0100 : 4'b0000);
        @(posedge i_Clock);
        #1;
        i_Valid = '0;
        i_Reset = 1'b1;
        @(negedge i_Clock);
        check("mid_rst_ready", o_Ready, 4'h0);
        @(posedge i_Clock);
        @(negedge i_Clock);
        check("mid_rst_valid", o_Valid, 0);
        check("mid_rst_output", o_Output, 0);
        @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        i_Ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_Clock);
            check("mid_no_replay", o_Valid, 0);
        end
        @(posedge i_Clock);
        #1;
        send(2, 32'hD000_0001, 4'h0, 1'b1);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
